// File: rtl/utils_pkg.sv
// Shared AXI4 types, encodings and helpers for the memory-mapped responders.
// Also holds the FSM state enums and beat-address arithmetic used by axi_mem.
package utils_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   awid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
        logic                  awvalid;
        logic [AXI_DATA_W-1:0] wdata;
        logic [AXI_STRB_W-1:0] wstrb;
        logic                  wlast;
        logic                  wvalid;
        logic                  bready;
        logic [AXI_ID_W-1:0]   arid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  arvalid;
        logic                  rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [AXI_ID_W-1:0]   bid;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_ID_W-1:0]   rid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  rvalid;
    } s_axi_miso_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_WAIT} r_state_e;

    // A beat is in error if the burst type or size is unsupported or it falls outside the window.
    function automatic logic beat_err(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] mem_bytes, input logic [2:0] size,
                                      input logic [1:0] burst);
        logic [31:0] off;
        off = addr - base;
        return (burst == AXI_BURST_WRAP) || (size > 3'd2) || (addr < base) || (off >= mem_bytes);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == AXI_BURST_FIXED) ? addr : addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-organised storage: one byte-enabled write port, one registered read port.
// A same-cycle read and write of one word returns the old contents.
module axi_mem_array
    import utils_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  we_i,
    input  logic [AXI_STRB_W-1:0] wbe_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [AXI_DATA_W-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [AXI_DATA_W-1:0] rdata_o
);

    logic [AXI_DATA_W-1:0] mem_q [2**ADDR_W];
    logic [AXI_DATA_W-1:0] rdata_q;

    // NOTE: the storage array is deliberately not reset so it maps onto RAM; only the read register is.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem.sv
// AXI4 memory responder with independent single-burst write and read FSMs.
// Out-of-window, WRAP and oversized beats answer SLVERR; reads return zero for them.
module axi_mem
    import utils_pkg::*;
#(
    parameter int          MEM_KB    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        arst,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o
);

    localparam int          WORDS     = MEM_KB * 256;
    localparam int          IDX_W     = $clog2(WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_KB * 1024);

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    // Holds the readies low until the first edge after reset is released.
    logic live_q;

    w_state_e          w_state_q, w_state_d;
    logic [31:0]       w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [AXI_ID_W-1:0] w_id_q, w_id_d;
    logic              w_err_q, w_err_d;

    r_state_e          r_state_q, r_state_d;
    logic [31:0]       r_addr_q, r_addr_d;
    logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [AXI_ID_W-1:0] r_id_q, r_id_d;
    logic              r_err_q, r_err_d;

    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic w_last_beat, w_beat_bad, r_last_beat;
    logic mem_we, mem_re;
    logic [AXI_DATA_W-1:0] mem_rdata;

    assign aw_ready    = live_q && (w_state_q == W_IDLE);
    assign w_ready     = (w_state_q == W_DATA);
    assign b_valid     = (w_state_q == W_RESP);
    assign ar_ready    = live_q && (r_state_q == R_IDLE);
    assign r_valid     = (r_state_q == R_DATA) || (r_state_q == R_WAIT);
    assign w_last_beat = (w_beat_q == w_len_q);
    assign r_last_beat = (r_beat_q == r_len_q);
    assign w_beat_bad  = beat_err(w_addr_q, BASE_ADDR, MEM_BYTES, w_size_q, w_burst_q);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_err_q   <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_id_q    <= w_id_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_id_q    <= r_id_d;
            r_err_q   <= r_err_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_id_d    = w_id_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (aw_ready && axi_mosi_i.awvalid) begin
                w_addr_d  = axi_mosi_i.awaddr;
                w_len_d   = axi_mosi_i.awlen;
                w_size_d  = axi_mosi_i.awsize;
                w_burst_d = axi_mosi_i.awburst;
                w_id_d    = axi_mosi_i.awid;
                w_beat_d  = '0;
                w_err_d   = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (axi_mosi_i.wvalid) begin
                mem_we  = !w_beat_bad;
                w_err_d = w_err_q || w_beat_bad || (axi_mosi_i.wlast != w_last_beat);
                if (w_last_beat) begin
                    w_state_d = W_RESP;
                end else begin
                    w_beat_d = w_beat_q + 8'd1;
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                end
            end
            W_RESP: if (axi_mosi_i.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Each issued read is registered in the array and presented on the following cycle.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_id_d    = r_id_q;
        r_err_d   = r_err_q;
        mem_re    = 1'b0;
        case (r_state_q)
            R_IDLE: if (ar_ready && axi_mosi_i.arvalid) begin
                r_addr_d  = axi_mosi_i.araddr;
                r_len_d   = axi_mosi_i.arlen;
                r_size_d  = axi_mosi_i.arsize;
                r_burst_d = axi_mosi_i.arburst;
                r_id_d    = axi_mosi_i.arid;
                r_beat_d  = '0;
                mem_re    = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA, R_WAIT: begin
                if (!axi_mosi_i.rready) begin
                    r_state_d = R_WAIT;
                end else if (r_last_beat) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_beat_d  = r_beat_q + 8'd1;
                    r_addr_d  = next_addr(r_addr_q, r_size_q, r_burst_q);
                    mem_re    = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (mem_re) r_err_d = beat_err(r_addr_d, BASE_ADDR, MEM_BYTES, r_size_d, r_burst_d);
    end

    axi_mem_array #(.ADDR_W(IDX_W)) u_array (
        .clk     (clk),
        .arst    (arst),
        .we_i    (mem_we),
        .wbe_i   (axi_mosi_i.wstrb),
        .waddr_i (word_idx(w_addr_q)),
        .wdata_i (axi_mosi_i.wdata),
        .re_i    (mem_re),
        .raddr_i (word_idx(r_addr_d)),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        axi_miso_o         = '0;
        axi_miso_o.awready = aw_ready;
        axi_miso_o.wready  = w_ready;
        axi_miso_o.bvalid  = b_valid;
        axi_miso_o.bid     = w_id_q;
        axi_miso_o.bresp   = (b_valid && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi_miso_o.arready = ar_ready;
        axi_miso_o.rvalid  = r_valid;
        axi_miso_o.rid     = r_id_q;
        axi_miso_o.rdata   = (r_valid && !r_err_q) ? mem_rdata : '0;
        axi_miso_o.rresp   = (r_valid && r_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi_miso_o.rlast   = r_valid && r_last_beat;
    end

endmodule

// File: tb/tb_axi_mem.sv
// Directed bench for axi_mem: single and burst transfers, strobes, range errors,
// protocol errors and reset in mid-burst, all against hand-computed values.
module tb_axi_mem;
    import utils_pkg::*;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;

    axi_mem #(.MEM_KB(8), .BASE_ADDR(32'h8000_0000)) dut (
        .clk        (clk),
        .arst       (arst),
        .axi_mosi_i (mosi),
        .axi_miso_o (miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wbuf  [16];
    logic [31:0] rbuf  [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];
    logic [3:0]  ridbuf[16];
    logic [1:0]  bresp;
    logic [3:0]  bid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n;
        n = 0;
        mosi.awaddr = addr; mosi.awlen = len; mosi.awsize = size;
        mosi.awburst = burst; mosi.awid = id; mosi.awvalid = 1'b1;
        while (!miso.awready && n < 50) begin tick(); n++; end
        if (n >= 50) check("aw_timeout", 0, 1);
        tick();
        mosi.awvalid = 1'b0;
    endtask

    task automatic w_send(input int nbeats, input logic [3:0] strb, input int last_at);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            n = 0;
            mosi.wdata = wbuf[i]; mosi.wstrb = strb;
            mosi.wlast = (i == last_at); mosi.wvalid = 1'b1;
            while (!miso.wready && n < 50) begin tick(); n++; end
            if (n >= 50) check("w_timeout", i, nbeats);
            tick();
        end
        mosi.wvalid = 1'b0;
        mosi.wlast  = 1'b0;
    endtask

    task automatic b_get(output logic [1:0] resp, output logic [3:0] id);
        int n;
        n = 0;
        mosi.bready = 1'b1;
        while (!miso.bvalid && n < 50) begin tick(); n++; end
        if (n >= 50) check("b_timeout", 0, 1);
        resp = miso.bresp;
        id   = miso.bid;
        tick();
        mosi.bready = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n;
        n = 0;
        mosi.araddr = addr; mosi.arlen = len; mosi.arsize = size;
        mosi.arburst = burst; mosi.arid = id; mosi.arvalid = 1'b1;
        while (!miso.arready && n < 50) begin tick(); n++; end
        if (n >= 50) check("ar_timeout", 0, 1);
        tick();
        mosi.arvalid = 1'b0;
        check("r_first_latency", miso.rvalid, 1);
    endtask

    // toggle=1 drives rready 1,0,1,0,... and checks the held beat during each stall.
    task automatic r_collect(input int nbeats, input bit toggle);
        int          got, cyc;
        bit          stalled;
        logic [31:0] prev;
        got = 0; cyc = 0; stalled = 0; prev = '0;
        while (got < nbeats && cyc < 200) begin
            mosi.rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (miso.rvalid) begin
                if (stalled) check("r_stall_stable", miso.rdata, prev);
                if (mosi.rready) begin
                    rbuf[got] = miso.rdata; rrbuf[got] = miso.rresp;
                    rlbuf[got] = miso.rlast; ridbuf[got] = miso.rid;
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev    = miso.rdata;
                end
            end
            tick();
            cyc++;
        end
        mosi.rready = 1'b0;
        if (got < nbeats) check("r_timeout", got, nbeats);
    endtask

    task automatic write1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wbuf[0] = data;
        aw_send(addr, 8'd0, 3'd2, AXI_BURST_INCR, 4'h1);
        w_send(1, strb, 0);
        b_get(bresp, bid);
    endtask

    task automatic read1(input logic [31:0] addr);
        ar_send(addr, 8'd0, 3'd2, AXI_BURST_INCR, 4'h2);
        r_collect(1, 1'b0);
    endtask

    initial begin
        mosi = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", miso.awready, 0);
        check("rst_arready", miso.arready, 0);
        check("rst_bvalid", miso.bvalid, 0);
        check("rst_rvalid", miso.rvalid, 0);
        check("rst_rdata", miso.rdata, 0);
        #2 arst = 1'b1;
        #1 check("rel_awready_pre_edge", miso.awready, 0);
        tick();
        check("rel_awready", miso.awready, 1);
        check("rel_arready", miso.arready, 1);

        // Single write then read-back
        wbuf[0] = 32'hDEAD_BEEF;
        aw_send(32'h8000_0010, 8'd0, 3'd2, AXI_BURST_INCR, 4'h3);
        w_send(1, 4'hF, 0);
        b_get(bresp, bid);
        check("single_bresp", bresp, AXI_RESP_OKAY);
        check("single_bid", bid, 4'h3);
        ar_send(32'h8000_0010, 8'd0, 3'd2, AXI_BURST_INCR, 4'h5);
        r_collect(1, 1'b0);
        check("single_rdata", rbuf[0], 32'hDEAD_BEEF);
        check("single_rlast", rlbuf[0], 1);
        check("single_rresp", rrbuf[0], AXI_RESP_OKAY);
        check("single_rid", ridbuf[0], 4'h5);
        check("single_rvalid_done", miso.rvalid, 0);

        // INCR burst with read backpressure
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        aw_send(32'h8000_0100, 8'd3, 3'd2, AXI_BURST_INCR, 4'h7);
        w_send(4, 4'hF, 3);
        b_get(bresp, bid);
        check("burst_bresp", bresp, AXI_RESP_OKAY);
        ar_send(32'h8000_0100, 8'd3, 3'd2, AXI_BURST_INCR, 4'h8);
        r_collect(4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_rdata%0d", i), rbuf[i], 32'(i + 1));
            check($sformatf("burst_rlast%0d", i), rlbuf[i], (i == 3) ? 32'd1 : 32'd0);
        end

        // Byte strobes
        write1(32'h8000_0020, 32'h1111_1111, 4'hF);
        write1(32'h8000_0020, 32'hAABB_CCDD, 4'h5);
        read1(32'h8000_0020);
        check("strb_rdata", rbuf[0], 32'h11BB_11DD);

        // Out of range
        read1(32'h7FFF_FFFC);
        check("oor_rresp", rrbuf[0], AXI_RESP_SLVERR);
        check("oor_rdata", rbuf[0], 32'h0);
        write1(32'h8000_0000, 32'h1234_5678, 4'hF);
        check("base_bresp", bresp, AXI_RESP_OKAY);
        write1(32'h8000_2000, 32'hCAFE_F00D, 4'hF);
        check("oor_bresp", bresp, AXI_RESP_SLVERR);
        read1(32'h8000_0000);
        check("oor_mem_unchanged", rbuf[0], 32'h1234_5678);

        // Early wlast: all four beats taken, SLVERR reported
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        aw_send(32'h8000_0200, 8'd3, 3'd2, AXI_BURST_INCR, 4'h9);
        w_send(4, 4'hF, 1);
        b_get(bresp, bid);
        check("wlast_bresp", bresp, AXI_RESP_SLVERR);
        check("wlast_bid", bid, 4'h9);
        check("wlast_awready_after", miso.awready, 1);

        // FIXED burst keeps the address, WRAP is rejected
        wbuf[0] = 32'h0000_000A;
        wbuf[1] = 32'h0000_000B;
        aw_send(32'h8000_0300, 8'd1, 3'd2, AXI_BURST_FIXED, 4'h4);
        w_send(2, 4'hF, 1);
        b_get(bresp, bid);
        check("fixed_bresp", bresp, AXI_RESP_OKAY);
        read1(32'h8000_0300);
        check("fixed_rdata", rbuf[0], 32'h0000_000B);
        ar_send(32'h8000_0100, 8'd1, 3'd2, AXI_BURST_WRAP, 4'h6);
        r_collect(2, 1'b0);
        check("wrap_rresp0", rrbuf[0], AXI_RESP_SLVERR);
        check("wrap_rdata1", rbuf[1], 32'h0);
        check("wrap_rlast1", rlbuf[1], 1);

        // Reset in the middle of a read burst
        ar_send(32'h8000_0100, 8'd7, 3'd2, AXI_BURST_INCR, 4'hC);
        tick();
        check("mid_rvalid_before", miso.rvalid, 1);
        #2 arst = 1'b0;
        #1;
        check("mid_rst_rvalid", miso.rvalid, 0);
        check("mid_rst_arready", miso.arready, 0);
        check("mid_rst_rdata", miso.rdata, 0);
        #10 arst = 1'b1;
        #1 check("mid_rel_arready_pre_edge", miso.arready, 0);
        tick();
        check("mid_rel_arready", miso.arready, 1);
        check("mid_rel_rvalid", miso.rvalid, 0);
        read1(32'h8000_0010);
        check("mem_kept_over_reset", rbuf[0], 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
